min_sec_counter: RTL and testbench

//  Timebase and minute/second BCD chain for the alarm clock. Divides clk down to a 1 Hz tick.

---
 rtl/clock_pkg.sv | 18 +
 rtl/min_sec_counter_bcd_digit.sv | 39 +++
 rtl/min_sec_counter.sv | 93 +++++++++
 tb/tb_min_sec_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared types, digit limits and helpers for the alarm-clock
// time-of-day chain.
//   bcd_t          one BCD digit (4 bits)
//   BCD_MAX_UNITS  highest value of a units digit (9)
//   BCD_MAX_TENS   highest value of a minutes/seconds tens digit (5)
//   bcd_clamp()    returns the digit, or 0 when it exceeds the given maximum
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_UNITS = 4'd9;
  localparam bcd_t BCD_MAX_TENS  = 4'd5;

  function automatic bcd_t bcd_clamp(input bcd_t digit, input bcd_t max_digit);
    return (digit > max_digit) ? 4'd0 : digit;
  endfunction

endpackage

// File: rtl/min_sec_counter_bcd_digit.sv
// bcd_digit: one modulo-(MAX+1) BCD digit of the counting chain.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high clear (highest priority)
//   inc    in   advance by one, wrapping MAX -> 0
//   load   in   load d (takes precedence over inc)
//   d      in   value to load; the caller guarantees it is <= MAX
//   q      out  current digit
//   wrap   out  inc while at MAX: the carry into the next digit
module bcd_digit
  import clock_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX_UNITS
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic load,
  input  bcd_t d,
  output bcd_t q,
  output logic wrap
);

  bcd_t q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end else if (inc) begin
      q_reg <= (q_reg == MAX) ? 4'd0 : q_reg + 4'd1;
    end
  end

  assign q    = q_reg;
  assign wrap = inc && (q_reg == MAX);

endmodule

// File: rtl/min_sec_counter.sv
// min_sec_counter: 1 Hz timebase plus MM:SS BCD counter for the alarm clock.
// Optional build macro: FAST_TICK_EN adds the 'fast' input, which turns every
// running cycle into a second tick for quick setting and simulation.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset, highest priority
//   run       in   1 = timebase advances, 0 = prescaler and digits frozen
//   set       in   load minutes from new_min, clear seconds and prescaler
//   new_min   in   BCD minutes {tens, units}; out-of-range digits load as 0
//   fast      in   (FAST_TICK_EN only) tick every cycle while running
//   min_t     out  minutes tens digit 0..5
//   min_u     out  minutes units digit 0..9
//   sec_t     out  seconds tens digit 0..5
//   sec_u     out  seconds units digit 0..9
//   sec_tick  out  one-cycle pulse on each 1 s boundary
//   hr_inc    out  one-cycle pulse on the 59:59 -> 00:00 rollover
module min_sec_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set,
  input  logic [7:0] new_min,
`ifdef FAST_TICK_EN
  input  logic       fast,
`endif
  output bcd_t       min_t,
  output bcd_t       min_u,
  output bcd_t       sec_t,
  output bcd_t       sec_u,
  output logic       sec_tick,
  output logic       hr_inc
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pre_reg;
  logic          fast_mode;
  logic          tick;
  logic          sec_u_wrap;
  logic          sec_t_wrap;
  logic          min_u_wrap;
  logic          min_t_wrap;

`ifdef FAST_TICK_EN
  assign fast_mode = fast;
`else
  assign fast_mode = 1'b0;
`endif

  // A set or reset in the same cycle swallows the tick so that no carry
  // (and in particular no hr_inc) escapes while the chain is being loaded.
  assign tick = run && (fast_mode || (pre_reg == PRE_LAST)) && !set && !reset;

  always_ff @(posedge clk) begin
    if (reset || set || fast_mode) begin
      pre_reg <= '0;
    end else if (run) begin
      pre_reg <= (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
    end
  end

  bcd_digit #(.MAX(BCD_MAX_UNITS)) u_sec_u (
    .clk(clk), .reset(reset), .inc(tick), .load(set), .d(4'd0),
    .q(sec_u), .wrap(sec_u_wrap)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_t (
    .clk(clk), .reset(reset), .inc(sec_u_wrap), .load(set), .d(4'd0),
    .q(sec_t), .wrap(sec_t_wrap)
  );

  bcd_digit #(.MAX(BCD_MAX_UNITS)) u_min_u (
    .clk(clk), .reset(reset), .inc(sec_t_wrap), .load(set),
    .d(bcd_clamp(new_min[3:0], BCD_MAX_UNITS)),
    .q(min_u), .wrap(min_u_wrap)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_min_t (
    .clk(clk), .reset(reset), .inc(min_u_wrap), .load(set),
    .d(bcd_clamp(new_min[7:4], BCD_MAX_TENS)),
    .q(min_t), .wrap(min_t_wrap)
  );

  assign sec_tick = tick;
  // The carry out of the top digit is exactly the 59:59 tick.
  assign hr_inc   = min_t_wrap;

endmodule

// File: tb/tb_min_sec_counter.sv
module tb_min_sec_counter;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       set = 1'b0;
  logic [7:0] new_min = 8'h00;
  logic       fast = 1'b0;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       sec_tick, hr_inc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time of day as a plain second count 0..3599.
  int m_secs = 0;
  int m_pre  = 0;
  int tick_cnt = 0;
  int hr_cnt = 0;
  int cyc = 0;
  int last_hr_cyc = -1;

  always #5 clk = ~clk;

  min_sec_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .run(run), .set(set), .new_min(new_min),
`ifdef FAST_TICK_EN
    .fast(fast),
`endif
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .sec_tick(sec_tick), .hr_inc(hr_inc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    int m, s;
    m = m_secs / 60;
    s = m_secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // One clock: inputs are already driven (at negedge); check the
  // combinational strobes, step the model on the edge, then check digits.
  task automatic cycle();
    logic e_tick, e_hr;
    int mins, tens, units;
    #1;
    e_tick = !reset && !set && run && (fast || m_pre == TPS - 1);
    e_hr   = e_tick && (m_secs == 3599);
    check("sec_tick", 32'(sec_tick), 32'(e_tick));
    check("hr_inc", 32'(hr_inc), 32'(e_hr));
    @(posedge clk);
    cyc++;
    if (sec_tick) tick_cnt++;
    if (hr_inc) begin
      hr_cnt++;
      last_hr_cyc = cyc;
    end
    if (reset) begin
      m_pre = 0;
      m_secs = 0;
    end else if (set) begin
      tens  = (new_min[7:4] > 4'd5) ? 0 : int'(new_min[7:4]);
      units = (new_min[3:0] > 4'd9) ? 0 : int'(new_min[3:0]);
      mins  = tens * 10 + units;
      m_secs = mins * 60;
      m_pre = 0;
    end else begin
      if (fast) m_pre = 0;
      else if (run) m_pre = (m_pre == TPS - 1) ? 0 : m_pre + 1;
      if (e_tick) m_secs = (m_secs + 1) % 3600;
    end
    #1;
    check("digits", 32'({min_t, min_u, sec_t, sec_u}), 32'(exp_digits()));
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_set(input logic [7:0] v);
    set = 1'b1;
    new_min = v;
    cycle();
    set = 1'b0;
    $display("[TB] set new_min=%02h -> %0h%0h:%0h%0h", v, min_t, min_u, sec_t, sec_u);
  endtask

  initial begin
    logic [15:0] held;
    int h0;
    @(negedge clk);

    // 1: reset then 40 running cycles
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    run = 1'b1;
    tick_cnt = 0;
    hr_cnt = 0;
    cycles(40);
    check("t1_ticks", 32'(tick_cnt), 32'd10);
    check("t1_digits", 32'({min_t, min_u, sec_t, sec_u}), 32'h0010);
    check("t1_hr", 32'(hr_cnt), 32'd0);
    $display("[TB] test1 ticks=%0d time=%0h%0h:%0h%0h", tick_cnt, min_t, min_u, sec_t, sec_u);

    // 2: set 59, run to 59:59 and through the rollover
    do_set(8'h59);
    cycles(59 * TPS);
    check("t2_5959", 32'({min_t, min_u, sec_t, sec_u}), 32'h5959);
    hr_cnt = 0;
    cycles(TPS);
    check("t2_hr_cnt", 32'(hr_cnt), 32'd1);
    check("t2_0000", 32'({min_t, min_u, sec_t, sec_u}), 32'h0000);
    $display("[TB] test2 rollover hr_inc count=%0d", hr_cnt);

    // 3: out-of-range minute digits
    do_set(8'h7A);
    check("t3_7A", 32'({min_t, min_u, sec_t, sec_u}), 32'h0000);
    do_set(8'h5C);
    check("t3_5C", 32'({min_t, min_u, sec_t, sec_u}), 32'h5000);

    // 4: set on the very cycle that would roll over 59:59
    do_set(8'h59);
    cycles(59 * TPS + TPS - 1);
    hr_cnt = 0;
    do_set(8'h23);
    check("t4_hr", 32'(hr_cnt), 32'd0);
    check("t4_digits", 32'({min_t, min_u, sec_t, sec_u}), 32'h2300);
    tick_cnt = 0;
    cycles(TPS - 1);
    check("t4_pre_clear", 32'(tick_cnt), 32'd0);
    cycles(1);
    check("t4_first_tick", 32'(tick_cnt), 32'd1);

    // 5: freeze, then reset together with set
    cycles(6);
    held = {min_t, min_u, sec_t, sec_u};
    run = 1'b0;
    tick_cnt = 0;
    cycles(20);
    check("t5_hold", 32'({min_t, min_u, sec_t, sec_u}), 32'(held));
    check("t5_ticks", 32'(tick_cnt), 32'd0);
    run = 1'b1;
    reset = 1'b1;
    set = 1'b1;
    new_min = 8'h42;
    cycle();
    reset = 1'b0;
    set = 1'b0;
    check("t5_reset", 32'({min_t, min_u, sec_t, sec_u}), 32'h0000);
    $display("[TB] test5 held=%04h after reset=%0h%0h:%0h%0h", held, min_t, min_u, sec_t, sec_u);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      run     = ($urandom_range(0, 7) != 0);
      set     = ($urandom_range(0, 40) == 0);
      reset   = ($urandom_range(0, 150) == 0);
      new_min = 8'($urandom);
      if (set && $urandom_range(0, 1) == 1) new_min = 8'h59;
`ifdef FAST_TICK_EN
      fast    = ($urandom_range(0, 5) == 0);
`endif
      cycle();
    end
    reset = 1'b0;
    set = 1'b0;
    fast = 1'b0;
    run = 1'b1;
    $display("[TB] random phase done, time=%0h%0h:%0h%0h", min_t, min_u, sec_t, sec_u);

`ifdef FAST_TICK_EN
    // 6: one hour of fast ticks from 00:00
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    fast = 1'b1;
    hr_cnt = 0;
    h0 = cyc;
    cycles(3600);
    fast = 1'b0;
    check("t6_hr_cnt", 32'(hr_cnt), 32'd1);
    check("t6_hr_cyc", 32'(last_hr_cyc - h0), 32'd3600);
    check("t6_digits", 32'({min_t, min_u, sec_t, sec_u}), 32'h0000);
    $display("[TB] test6 fast hour hr_inc count=%0d", hr_cnt);
`else
    h0 = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
